// File: rtl/mux_pkg.sv
// Types shared by the mux block family.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping to 0.
module mux_rr_arbiter #(
  parameter  int NB_CH = 8,
  localparam int SEL_W = $clog2(NB_CH)
) (
  input  logic [NB_CH-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gntValid
);

  localparam logic [SEL_W:0] NB = (SEL_W+1)'(NB_CH);

  logic [2*NB_CH-2:0] reqDbl;
  logic [NB_CH-1:0]   rot;
  logic [SEL_W-1:0]   off;
  logic [SEL_W:0]     sum;

  // Top copy drops its MSB: ptr never exceeds NB_CH-1, so that bit is never reached.
  assign reqDbl = {req[NB_CH-2:0], req};
  assign rot    = reqDbl[ptr +: NB_CH];

  always_comb begin
    off = '0;
    for (int i = NB_CH-1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  // Explicit wrap keeps non-power-of-2 channel counts correct.
  assign sum      = {1'b0, ptr} + {1'b0, off};
  assign gnt      = (sum >= NB) ? SEL_W'(sum - NB) : sum[SEL_W-1:0];
  assign gntValid = |req;

endmodule

// File: rtl/mux_n1w_rr.sv
// N-channel registered mux with valid/ready per channel, fixed or round-robin selection.
module mux_n1w_rr
  import mux_pkg::*;
#(
  parameter  int NB_CH  = 8,
  parameter  int DATA_W = 4,
  localparam int SEL_W  = $clog2(NB_CH)
) (
  input  logic                    inClk,
  input  logic                    inRst,
  input  logic [NB_CH*DATA_W-1:0] inData,
  input  logic [NB_CH-1:0]        inValid,
  output logic [NB_CH-1:0]        outReady,
  input  logic                    inMode,
  input  logic [SEL_W-1:0]        inSel,
  output logic [DATA_W-1:0]       outData,
  output logic [SEL_W-1:0]        outSel,
  output logic                    outValid,
  input  logic                    inReady
);

  localparam logic [SEL_W:0]   NB   = (SEL_W+1)'(NB_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NB_CH-1);

  logic             isRr, load, gntValid, fixValid, rrGntValid;
  logic [SEL_W-1:0] gnt, rrGnt, ptr;

  assign isRr = (inMode == MODE_RR);

  mux_rr_arbiter #(.NB_CH(NB_CH)) uArb (
    .req      (inValid),
    .ptr      (ptr),
    .gnt      (rrGnt),
    .gntValid (rrGntValid)
  );

  // Out-of-range select shifts the one-hot off the end, so it can never grant.
  assign fixValid = ({1'b0, inSel} < NB) && |(inValid & (NB_CH'(1) << inSel));

  assign gnt      = isRr ? rrGnt : inSel;
  assign gntValid = isRr ? rrGntValid : fixValid;
  assign load     = ~outValid | inReady;

  always_comb begin
    outReady = '0;
    for (int i = 0; i < NB_CH; i++)
      outReady[i] = ~inRst & load & gntValid & (gnt == SEL_W'(i));
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      outData  <= '0;
      outSel   <= '0;
      outValid <= 1'b0;
      ptr      <= '0;
    end else if (load) begin
      if (gntValid) begin
        outData  <= inData[gnt*DATA_W +: DATA_W];
        outSel   <= gnt;
        outValid <= 1'b1;
        if (isRr) ptr <= (gnt == LAST) ? '0 : gnt + SEL_W'(1);
      end else begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n1w_rr.sv
// Scoreboard bench for mux_n1w_rr: directed vectors, expected beats queued, monitor drains.
module tb_mux_n1w_rr;

  logic        inClk, inRst;
  logic [31:0] inData;
  logic [7:0]  inValid, outReady;
  logic        inMode, outValid, inReady;
  logic [2:0]  inSel, outSel;
  logic [3:0]  outData;

  logic [19:0] inData5;
  logic [4:0]  inValid5, outReady5;
  logic        inMode5, outValid5, inReady5;
  logic [2:0]  inSel5, outSel5;
  logic [3:0]  outData5;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb [$];
  int rrSeq [6] = '{0, 2, 5, 7, 0, 2};

  mux_n1w_rr #(.NB_CH(8), .DATA_W(4)) dut (
    .inClk(inClk), .inRst(inRst), .inData(inData), .inValid(inValid),
    .outReady(outReady), .inMode(inMode), .inSel(inSel), .outData(outData),
    .outSel(outSel), .outValid(outValid), .inReady(inReady));

  mux_n1w_rr #(.NB_CH(5), .DATA_W(4)) dut5 (
    .inClk(inClk), .inRst(inRst), .inData(inData5), .inValid(inValid5),
    .outReady(outReady5), .inMode(inMode5), .inSel(inSel5), .outData(outData5),
    .outSel(outSel5), .outValid(outValid5), .inReady(inReady5));

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; check combinational outReady; queue the beat that will load.
  task automatic step(input logic m, input logic [2:0] s, input logic [7:0] v,
                      input logic r, input logic [7:0] er, input bit push,
                      input logic [2:0] es);
    logic [3:0] ed;
    inMode = m; inSel = s; inValid = v; inReady = r;
    @(negedge inClk);
    chk("outReady", {24'd0, outReady}, {24'd0, er});
    ed = {1'b0, es} + 4'd1;
    if (push) sb.push_back({es, ed});
    @(posedge inClk); #1;
  endtask

  always @(negedge inClk) begin
    if (!inRst && outValid === 1'b1 && inReady === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedBeat: got sel %0d data %0h expected none", outSel, outData);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        chk("beatSel", {29'd0, outSel}, {29'd0, e[6:4]});
        chk("beatData", {28'd0, outData}, {28'd0, e[3:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) inData[i*4 +: 4] = 4'(i+1);
    for (int i = 0; i < 5; i++) inData5[i*4 +: 4] = 4'(i+1);

    // Reset with every channel valid
    inRst = 1'b1; inValid = 8'hFF; inReady = 1'b1; inMode = 1'b0; inSel = 3'd0;
    inValid5 = 5'h1F; inSel5 = 3'd4; inMode5 = 1'b0; inReady5 = 1'b1;
    @(negedge inClk);
    chk("rstReady", {24'd0, outReady}, 32'd0);
    chk("rstReady5", {27'd0, outReady5}, 32'd0);
    @(posedge inClk); #1;
    @(negedge inClk);
    chk("rstReady2", {24'd0, outReady}, 32'd0);
    @(posedge inClk); #1;
    chk("rstValid", {31'd0, outValid}, 32'd0);
    chk("rstData", {28'd0, outData}, 32'd0);
    chk("rstSel", {29'd0, outSel}, 32'd0);
    chk("rstValid5", {31'd0, outValid5}, 32'd0);
    inRst = 1'b0;

    // Fixed sweep, with the 5-channel instance alongside
    #1 chk("fix5Ready", {27'd0, outReady5}, 32'h10);
    step(1'b0, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
    chk("fix5Valid", {31'd0, outValid5}, 32'd1);
    chk("fix5Data", {28'd0, outData5}, 32'd5);
    chk("fix5Sel", {29'd0, outSel5}, 32'd4);
    inSel5 = 3'd6;
    #1 chk("oor5Ready", {27'd0, outReady5}, 32'd0);
    for (int s = 1; s < 8; s++)
      step(1'b0, 3'(s), 8'hFF, 1'b1, 8'(1 << s), 1'b1, 3'(s));
    chk("oor5Valid", {31'd0, outValid5}, 32'd0);
    chk("oor5Hold", {28'd0, outData5}, 32'd5);

    // Fixed select on an idle channel grants nothing
    step(1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 3'd0);
    chk("fixIdleValid", {31'd0, outValid}, 32'd0);

    // Round-robin fairness, inSel ignored
    for (int k = 0; k < 6; k++) begin
      int g;
      g = rrSeq[k];
      step(1'b1, 3'(7-k), 8'hA5, 1'b1, 8'(1 << g), 1'b1, 3'(g));
      chk("rrNoBubble", {31'd0, outValid}, 32'd1);
    end
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    chk("rrDrain", {31'd0, outValid}, 32'd0);

    // Backpressure from a fresh pointer
    inRst = 1'b1; inValid = 8'hFF;
    @(negedge inClk);
    chk("rst2Ready", {24'd0, outReady}, 32'd0);
    @(posedge inClk); #1;
    inRst = 1'b0;
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h01, 1'b1, 3'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0);
      chk("bpHoldData", {28'd0, outData}, 32'd1);
      chk("bpHoldSel", {29'd0, outSel}, 32'd0);
    end
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);
    chk("bpRelease", {29'd0, outSel}, 32'd1);

    // Reset while a beat is held under backpressure
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0);
    chk("heldValid", {31'd0, outValid}, 32'd1);
    inRst = 1'b1;
    @(negedge inClk);
    chk("rstMidReady", {24'd0, outReady}, 32'd0);
    sb.delete();
    @(posedge inClk); #1;
    chk("rstMidValid", {31'd0, outValid}, 32'd0);
    inRst = 1'b0;
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
    chk("rrRestart", {29'd0, outSel}, 32'd0);
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    chk("sbEmpty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
